// File: rtl/sample_com_if.sv
// sample_com_if: bus bundle for the sample_com registered binary decoder.
//   en        - decode enable (driven by master)
//   in        - binary code to decode, IN bits (driven by master)
//   out       - decoded vector, 1<<IN bits (driven by slave)
//   out_valid - out holds a decoded result rather than the reset value
//   out_code  - code that produced the current out
// Modports: master (code source), slave (decoder).
interface sample_com_if #(
    parameter int IN = 4
);
    localparam int OUT = 1 << IN;

    logic            en;
    logic [IN-1:0]   in;
    logic [OUT-1:0]  out;
    logic            out_valid;
    logic [IN-1:0]   out_code;

    modport master (
        output en,
        output in,
        input  out,
        input  out_valid,
        input  out_code
    );

    modport slave (
        input  en,
        input  in,
        output out,
        output out_valid,
        output out_code
    );
endinterface

// File: rtl/sample_com.sv
// sample_com: registered IN-to-(1<<IN) line decoder.
// Parameters:
//   IN  - width of the binary input code (1..8)
//   ACT - level driven on the selected output line; all others drive ~ACT
// Ports:
//   clk   - single clock, all state updates on the rising edge
//   reset - synchronous, active-high; forces out to all ~ACT, code 0, valid 0
//   bus   - sample_com_if slave modport (en, in, out, out_valid, out_code)
// Outputs come straight from flops, so there is no combinational path from
// in/en to any output. With en low the registered result holds.
module sample_com #(
    parameter int   IN  = 4,
    parameter logic ACT = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    sample_com_if.slave bus
);
    localparam int OUT = 1 << IN;

    logic [OUT-1:0] out_d,   out_q;
    logic [IN-1:0]  code_d,  code_q;
    logic           valid_d, valid_q;

    always_comb begin
        out_d   = out_q;
        code_d  = code_q;
        valid_d = valid_q;
        if (bus.en) begin
            // Fill with the inactive level, then raise the one selected line;
            // every code 0..OUT-1 maps to a real bit, so no range check exists.
            out_d          = {OUT{~ACT}};
            out_d[bus.in]  = ACT;
            code_d         = bus.in;
            valid_d        = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q   <= {OUT{~ACT}};
            code_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            code_q  <= code_d;
            valid_q <= valid_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_code  = code_q;
    assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_sample_com.sv
// tb_sample_com: directed bench for sample_com with a scoreboard queue.
// Four builds: IN=4/ACT=1, IN=4/ACT=0, IN=1/ACT=1, IN=8/ACT=1.
module tb_sample_com;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    sample_com_if #(.IN(4)) b0 ();
    sample_com_if #(.IN(4)) b1 ();
    sample_com_if #(.IN(1)) b2 ();
    sample_com_if #(.IN(8)) b3 ();

    sample_com #(.IN(4), .ACT(1'b1)) u0 (.clk(clk), .reset(reset), .bus(b0));
    sample_com #(.IN(4), .ACT(1'b0)) u1 (.clk(clk), .reset(reset), .bus(b1));
    sample_com #(.IN(1), .ACT(1'b1)) u2 (.clk(clk), .reset(reset), .bus(b2));
    sample_com #(.IN(8), .ACT(1'b1)) u3 (.clk(clk), .reset(reset), .bus(b3));

    typedef struct {
        int           dut;
        string        tag;
        logic [255:0] out;
        logic         valid;
        logic [7:0]   code;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic push(input int dut, input string tag, input logic [255:0] o,
                        input logic v, input logic [7:0] c);
        exp_t e;
        e.dut = dut; e.tag = tag; e.out = o; e.valid = v; e.code = c;
        sb.push_back(e);
    endtask

    // Advance one capturing edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_next();
        exp_t         e;
        logic [255:0] o;
        logic         v;
        logic [7:0]   c;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL scoreboard_empty: observed 0 entries, expected at least 1");
            return;
        end
        e = sb.pop_front();
        case (e.dut)
            0:       begin o = 256'(b0.out); v = b0.out_valid; c = 8'(b0.out_code); end
            1:       begin o = 256'(b1.out); v = b1.out_valid; c = 8'(b1.out_code); end
            2:       begin o = 256'(b2.out); v = b2.out_valid; c = 8'(b2.out_code); end
            default: begin o = b3.out;      v = b3.out_valid; c = b3.out_code;      end
        endcase
        n_tests++;
        assert (o === e.out) else begin
            n_fail++;
            $error("FAIL %s out: observed %h expected %h", e.tag, o, e.out);
        end
        n_tests++;
        assert (v === e.valid) else begin
            n_fail++;
            $error("FAIL %s out_valid: observed %b expected %b", e.tag, v, e.valid);
        end
        n_tests++;
        assert (c === e.code) else begin
            n_fail++;
            $error("FAIL %s out_code: observed %h expected %h", e.tag, c, e.code);
        end
    endtask

    task automatic check_all();
        while (sb.size() > 0) check_next();
    endtask

    initial begin
        logic [255:0] one;
        one = 256'd1;

        reset = 1'b1;
        b0.en = 1'b0; b0.in = '0;
        b1.en = 1'b0; b1.in = '0;
        b2.en = 1'b0; b2.in = '0;
        b3.en = 1'b0; b3.in = '0;

        // Reset values for all builds.
        push(0, "reset_a1",   256'h0000, 1'b0, 8'd0);
        push(1, "reset_a0",   256'hFFFF, 1'b0, 8'd0);
        push(2, "reset_in1",  256'h0,    1'b0, 8'd0);
        push(3, "reset_in8",  256'h0,    1'b0, 8'd0);
        step();
        check_all();
        reset = 1'b0;

        // Sweep every code back to back, one result per cycle.
        b0.en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            b0.in = 4'(i);
            push(0, $sformatf("sweep_%0d", i), one << i, 1'b1, 8'(i));
            step();
            check_next();
        end

        // Same code again keeps out steady with valid still high.
        b0.in = 4'd15;
        push(0, "repeat_15", 256'h8000, 1'b1, 8'd15);
        step();
        check_next();

        // Capture 5, then hold with en low and a different code on in.
        b0.in = 4'd5;
        push(0, "capture_5", 256'h0020, 1'b1, 8'd5);
        step();
        check_next();
        b0.en = 1'b0;
        b0.in = 4'd9;
        for (int i = 0; i < 3; i++) begin
            push(0, $sformatf("hold_%0d", i), 256'h0020, 1'b1, 8'd5);
            step();
            check_next();
        end

        // Active-low build.
        b1.en = 1'b1;
        b1.in = 4'd3;
        push(1, "act0_in3", 256'hFFF7, 1'b1, 8'd3);
        step();
        check_next();
        b1.in = 4'd15;
        push(1, "act0_in15", 256'h7FFF, 1'b1, 8'd15);
        step();
        check_next();
        b1.en = 1'b0;
        b1.in = 4'd0;
        push(1, "act0_hold", 256'h7FFF, 1'b1, 8'd15);
        step();
        check_next();

        // Width extremes: all-ones selects the MSB only.
        b2.en = 1'b1;
        b2.in = 1'b1;
        b3.en = 1'b1;
        b3.in = 8'hFF;
        push(2, "in1_ones", 256'h2,      1'b1, 8'd1);
        push(3, "in8_ones", one << 255,  1'b1, 8'hFF);
        step();
        check_all();
        b2.in = 1'b0;
        b3.in = 8'h00;
        push(2, "in1_zero", 256'h1, 1'b1, 8'd0);
        push(3, "in8_zero", 256'h1, 1'b1, 8'd0);
        step();
        check_all();
        b2.en = 1'b0;
        b3.en = 1'b0;

        // Reset wins over a simultaneous enable, then normal operation resumes.
        b0.en = 1'b1;
        b0.in = 4'd7;
        b1.en = 1'b1;
        b1.in = 4'd2;
        reset = 1'b1;
        push(0, "rst_vs_en_a1", 256'h0000, 1'b0, 8'd0);
        push(1, "rst_vs_en_a0", 256'hFFFF, 1'b0, 8'd0);
        step();
        check_all();
        reset = 1'b0;
        push(0, "post_rst_7",   256'h0080, 1'b1, 8'd7);
        push(1, "post_rst_a0",  256'hFFFB, 1'b1, 8'd2);
        step();
        check_all();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety bound so the bench always ends on its own.
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, expected finish before 100000");
        $fatal(1, "timeout");
    end
endmodule
